shifter_arbiter: RTL and testbench

//  Shares one 8-bit Barrel_Shifter between two requesters. Each requester uses a valid/ready handshake.
//  The arbiter grants one request per cycle (round-robin) and drives the operands into the shifter.
//  The result is registered and returned with the winner's id on a valid/ready result channel.
//  It sits between ALU-side requesters and the shared shift datapath.

---
 rtl/shifter_arbiter.sv | 118 +++++++++++
 tb/tb_shifter_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Purpose : round-robin arbiter sharing one 8-bit barrel shifter between two requesters.
// Latency : 1 cycle from accept to res_valid; 1 op/cycle while res_ready=1.
// Backpr. : while a result is held and res_ready=0, both reqN_ready are 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reqN_valid/ready  requester N handshake (N=0,1); ready is combinational
//   reqN_din          operand, reqN_shamt shift amount 0..7
//   reqN_lr           1=left, 0=right; reqN_al 1=arithmetic right shift
//   res_valid/ready   result handshake; res_dout result, res_id winning requester
//
// Build option: define SHIFTER_ARB_FIXED_PRIO_EN to make requester 0 always
// win a conflict (no round-robin priority flop). Default is round-robin.
module shifter_arbiter #(
  parameter int WIDTH   = 8,  // must be 8: shamt is 3 bits wide
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_din,
  input  logic [2:0]       req0_shamt,
  input  logic             req0_lr,
  input  logic             req0_al,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_din,
  input  logic [2:0]       req1_shamt,
  input  logic             req1_lr,
  input  logic             req1_al,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_dout,
  output logic             res_id
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   can_accept;
  logic   grant0;
  logic   grant1;
  logic   accept;

  // Selected operands (winner's) feeding the shared shifter
  logic [WIDTH-1:0] op_din;
  logic [2:0]       op_shamt;
  logic             op_lr;
  logic             op_al;

  // Barrel shifter stage outputs
  logic             fill;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

`ifndef SHIFTER_ARB_FIXED_PRIO_EN
  logic prio;  // requester that wins when both are valid
`endif

  assign res_valid  = (state == FULL);

  // A held result that is consumed this cycle frees the register for a new one.
  assign can_accept = (state == IDLE) | (res_ready & res_valid);

`ifdef SHIFTER_ARB_FIXED_PRIO_EN
  assign grant1 = req1_valid & ~req0_valid;
`else
  assign grant1 = req1_valid & (~req0_valid | prio);
`endif
  assign grant0 = req0_valid & ~grant1;

  // Reset blocks every handshake in the cycle it is asserted.
  assign req0_ready = ~rst & can_accept & grant0;
  assign req1_ready = ~rst & can_accept & grant1;
  assign accept     = req0_ready | req1_ready;

  assign op_din   = grant1 ? req1_din   : req0_din;
  assign op_shamt = grant1 ? req1_shamt : req0_shamt;
  assign op_lr    = grant1 ? req1_lr    : req0_lr;
  assign op_al    = grant1 ? req1_al    : req0_al;

  // Sign fill only for arithmetic right shifts; al is ignored on left shifts.
  assign fill = ~op_lr & op_al & op_din[WIDTH-1];

  assign s0 = ~op_shamt[0] ? op_din :
              op_lr        ? {op_din[WIDTH-2:0], 1'b0} :
                             {fill, op_din[WIDTH-1:1]};
  assign s1 = ~op_shamt[1] ? s0 :
              op_lr        ? {s0[WIDTH-3:0], 2'b00} :
                             {{2{fill}}, s0[WIDTH-1:2]};
  assign s2 = ~op_shamt[2] ? s1 :
              op_lr        ? {s1[WIDTH-5:0], 4'b0000} :
                             {{4{fill}}, s1[WIDTH-1:4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      res_dout <= '0;
      res_id   <= 1'b0;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
      prio     <= (RR_INIT != 0);
`endif
    end else if (accept) begin
      // Also covers consume+accept in FULL: reload with no bubble.
      state    <= FULL;
      res_dout <= s2;
      res_id   <= grant1;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
      prio     <= ~grant1;
`endif
    end else if ((state == FULL) && res_ready) begin
      state <= IDLE;  // res_dout keeps its last value
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_lr, req0_al;
  logic [7:0] req0_din;
  logic [2:0] req0_shamt;
  logic       req1_valid, req1_ready, req1_lr, req1_al;
  logic [7:0] req1_din;
  logic [2:0] req1_shamt;
  logic       res_valid, res_ready, res_id;
  logic [7:0] res_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(.WIDTH(8), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_din   (req0_din),
    .req0_shamt (req0_shamt),
    .req0_lr    (req0_lr),
    .req0_al    (req0_al),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_din   (req1_din),
    .req1_shamt (req1_shamt),
    .req1_lr    (req1_lr),
    .req1_al    (req1_al),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_dout   (res_dout),
    .res_id     (res_id)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      $error("%s observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic lr, input logic al);
    req0_valid = v; req0_din = d; req0_shamt = s; req0_lr = lr; req0_al = al;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic lr, input logic al);
    req1_valid = v; req1_din = d; req1_shamt = s; req1_lr = lr; req1_al = al;
  endtask

  initial begin
    logic [7:0] held_dout;
    logic       held_id;
    logic       exp_id;

    // 1. Reset for two cycles with both requests pending
    rst = 1'b1; res_ready = 1'b1;
    set0(1'b1, 8'h55, 3'd1, 1'b1, 1'b0);
    set1(1'b1, 8'hAA, 3'd1, 1'b1, 1'b0);
    #1;
    check("rst_req0_ready", 8'(req0_ready), 8'h00);
    check("rst_req1_ready", 8'(req1_ready), 8'h00);
    tick();
    check("rst_req0_ready_c1", 8'(req0_ready), 8'h00);
    tick();
    check("rst_res_valid", 8'(res_valid), 8'h00);
    check("rst_res_dout",  res_dout,        8'h00);
    check("rst_res_id",    8'(res_id),      8'h00);
    check("rst_req1_ready_c2", 8'(req1_ready), 8'h00);
    rst = 1'b0;
    set0(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    check("idle_req0_ready", 8'(req0_ready), 8'h00);
    check("idle_res_valid",  8'(res_valid),  8'h00);

    // 2. Shift modes from requester 0, back-to-back
    set0(1'b1, 8'h96, 3'd3, 1'b0, 1'b1);
    #1;
    check("asr_req0_ready", 8'(req0_ready), 8'h01);
    check("asr_req1_ready", 8'(req1_ready), 8'h00);
    tick();
    check("asr_res_valid", 8'(res_valid), 8'h01);
    check("asr_res_dout",  res_dout,      8'hF2);
    check("asr_res_id",    8'(res_id),    8'h00);
    set0(1'b1, 8'h96, 3'd3, 1'b0, 1'b0);
    #1;
    check("lsr_req0_ready", 8'(req0_ready), 8'h01);
    tick();
    check("lsr_res_dout", res_dout,      8'h12);
    check("lsr_res_valid", 8'(res_valid), 8'h01);
    set0(1'b1, 8'h96, 3'd3, 1'b1, 1'b1);
    tick();
    check("lsl_res_dout", res_dout,   8'hB0);
    check("lsl_res_id",   8'(res_id), 8'h00);

    // Shift amount boundary from requester 1
    set0(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h96, 3'd7, 1'b0, 1'b1);
    #1;
    check("r1_req1_ready", 8'(req1_ready), 8'h01);
    tick();
    check("asr7_res_dout", res_dout,   8'hFF);
    check("asr7_res_id",   8'(res_id), 8'h01);
    set1(1'b1, 8'h96, 3'd7, 1'b0, 1'b0);
    tick();
    check("lsr7_res_dout", res_dout, 8'h01);
    set1(1'b1, 8'h96, 3'd0, 1'b1, 1'b0);
    tick();
    check("sh0_res_dout", res_dout, 8'h96);

    // Drain: consumed with no request -> IDLE, dout retained
    set1(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check("drain_res_valid", 8'(res_valid), 8'h00);
    check("drain_res_dout",  res_dout,      8'h96);

    // 3. Contention: reset to restore prio, then both valid every cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 8'h01, 3'd1, 1'b1, 1'b0);  // -> 0x02
    set1(1'b1, 8'h80, 3'd1, 1'b0, 1'b0);  // -> 0x40
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      #1;
      check("rr_req0_ready", 8'(req0_ready), 8'(!exp_id));
      check("rr_req1_ready", 8'(req1_ready), 8'(exp_id));
      tick();
      check("rr_res_id",   8'(res_id), 8'(exp_id));
      check("rr_res_dout", res_dout,   exp_id ? 8'h40 : 8'h02);
    end

    // 4. Backpressure for 4 cycles, then consume+accept in the same cycle
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
    held_dout = 8'h02; held_id = 1'b0;
`else
    held_dout = 8'h40; held_id = 1'b1;
`endif
    res_ready = 1'b0;
    set0(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h01, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_req0_ready", 8'(req0_ready), 8'h00);
      check("bp_req1_ready", 8'(req1_ready), 8'h00);
      tick();
      check("bp_res_valid", 8'(res_valid), 8'h01);
      check("bp_res_dout",  res_dout,      held_dout);
      check("bp_res_id",    8'(res_id),    8'(held_id));
    end
    res_ready = 1'b1;
    #1;
    check("cc_req1_ready", 8'(req1_ready), 8'h01);
    tick();
    check("cc_res_valid", 8'(res_valid), 8'h01);
    check("cc_res_dout",  res_dout,      8'h80);
    check("cc_res_id",    8'(res_id),    8'h01);

    // Requester 0 alone so round-robin priority now points at requester 1
    set1(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set0(1'b1, 8'h03, 3'd2, 1'b1, 1'b0);
    tick();
    check("pre5_res_dout", res_dout,   8'h0C);
    check("pre5_res_id",   8'(res_id), 8'h00);

    // 5. Reset while FULL with both requests pending
    rst = 1'b1;
    set0(1'b1, 8'h01, 3'd1, 1'b1, 1'b0);
    set1(1'b1, 8'h80, 3'd1, 1'b0, 1'b0);
    #1;
    check("r5_req0_ready", 8'(req0_ready), 8'h00);
    check("r5_req1_ready", 8'(req1_ready), 8'h00);
    tick();
    check("r5_res_valid", 8'(res_valid), 8'h00);
    check("r5_res_dout",  res_dout,      8'h00);
    check("r5_res_id",    8'(res_id),    8'h00);
    rst = 1'b0;
    #1;
    // Priority is back at RR_INIT=0, so requester 0 wins
    check("r5_prio_req0_ready", 8'(req0_ready), 8'h01);
    check("r5_prio_req1_ready", 8'(req1_ready), 8'h00);
    tick();
    check("r5_post_res_id",   8'(res_id), 8'h00);
    check("r5_post_res_dout", res_dout,   8'h02);

    set0(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check("end_res_valid", 8'(res_valid), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
